// File: rtl/pwm_cfg_arbiter.sv
// pwm_cfg_arbiter: owns the PWM configuration register bank (output enables,
// PWM enables, duty cycle) and shares write access between two requesters.
// After reset or a soft clear a five-cycle default-load sequence runs before
// either requester is granted.
// Optional build macro: PWM_CFG_ARB_FIXED_PRIO_EN selects fixed priority
// (req0 always wins a tie) instead of round-robin arbitration.
module pwm_cfg_arbiter #(
  parameter logic [7:0] OUT_DEFAULT  = 8'h00,
  parameter logic [7:0] DUTY_DEFAULT = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_clr,
  input  logic       req0_valid,
  input  logic [2:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       init_done,
  output logic       wr_strobe,
  output logic       wr_src,
  output logic [2:0] wr_addr,
  output logic       addr_err
);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [2:0] LAST_REG = 3'd4;

  logic [0:0]      state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [4:0][7:0] regs_q, regs_d;
  logic            init_done_q, init_done_d;
  logic            wr_strobe_q, wr_strobe_d;
  logic            wr_src_q, wr_src_d;
  logic [2:0]      wr_addr_q, wr_addr_d;
  logic            addr_err_q, addr_err_d;
`ifndef PWM_CFG_ARB_FIXED_PRIO_EN
  logic            last_winner_q, last_winner_d;
`endif

  logic       grant0_s, grant1_s;
  logic       run_s;
  logic       acc_s, acc_src_s;
  logic [2:0] acc_addr_s;
  logic [7:0] acc_data_s;

  // Grant selection from the current valids; ties resolved by build option.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef PWM_CFG_ARB_FIXED_PRIO_EN
      grant0_s = 1'b1;
`else
      // Tie goes to whoever did not win last time.
      if (last_winner_q) begin
        grant0_s = 1'b1;
      end else begin
        grant1_s = 1'b1;
      end
`endif
    end else if (req0_valid) begin
      grant0_s = 1'b1;
    end else if (req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Readies are gated by RUN and by a pending soft clear; handshake decode.
  always_comb begin
    run_s      = (state_q == ST_RUN);
    req0_ready = run_s & grant0_s & ~init_clr;
    req1_ready = run_s & grant1_s & ~init_clr;
    acc_s      = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    acc_src_s  = req1_valid & req1_ready;
    acc_addr_s = acc_src_s ? req1_addr : req0_addr;
    acc_data_s = acc_src_s ? req1_data : req0_data;
  end

  // Next-state logic: default-load sequence, requester writes, status pulses.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    addr_err_d  = 1'b0;
    wr_src_d    = wr_src_q;
    wr_addr_d   = wr_addr_q;
`ifndef PWM_CFG_ARB_FIXED_PRIO_EN
    last_winner_d = last_winner_q;
`endif
    if (init_clr) begin
      // Restart the default load; register contents get overwritten there.
      state_d = ST_INIT;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        ST_INIT: begin
          case (cnt_q)
            3'd0: regs_d[0] = OUT_DEFAULT;
            3'd1: regs_d[1] = OUT_DEFAULT;
            3'd2: regs_d[2] = OUT_DEFAULT;
            3'd3: regs_d[3] = OUT_DEFAULT;
            3'd4: regs_d[4] = DUTY_DEFAULT;
            default: regs_d = regs_q;
          endcase
          if (cnt_q >= LAST_REG) begin
            state_d = ST_RUN;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        ST_RUN: begin
          if (acc_s) begin
`ifndef PWM_CFG_ARB_FIXED_PRIO_EN
            last_winner_d = acc_src_s;
`endif
            if (acc_addr_s <= LAST_REG) begin
              case (acc_addr_s)
                3'd0: regs_d[0] = acc_data_s;
                3'd1: regs_d[1] = acc_data_s;
                3'd2: regs_d[2] = acc_data_s;
                3'd3: regs_d[3] = acc_data_s;
                3'd4: regs_d[4] = acc_data_s;
                default: regs_d = regs_q;
              endcase
              wr_strobe_d = 1'b1;
              wr_src_d    = acc_src_s;
              wr_addr_d   = acc_addr_s;
            end else begin
              // Out-of-range address: accepted so the requester never stalls.
              addr_err_d = 1'b1;
            end
          end else begin
            wr_strobe_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_INIT;
          cnt_d   = 3'd0;
        end
      endcase
    end
    init_done_d = (state_d == ST_RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= 3'd0;
      regs_q      <= '0;
      init_done_q <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_src_q    <= 1'b0;
      wr_addr_q   <= 3'd0;
      addr_err_q  <= 1'b0;
`ifndef PWM_CFG_ARB_FIXED_PRIO_EN
      last_winner_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      regs_q      <= regs_d;
      init_done_q <= init_done_d;
      wr_strobe_q <= wr_strobe_d;
      wr_src_q    <= wr_src_d;
      wr_addr_q   <= wr_addr_d;
      addr_err_q  <= addr_err_d;
`ifndef PWM_CFG_ARB_FIXED_PRIO_EN
      last_winner_q <= last_winner_d;
`endif
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign init_done       = init_done_q;
  assign wr_strobe       = wr_strobe_q;
  assign wr_src          = wr_src_q;
  assign wr_addr         = wr_addr_q;
  assign addr_err        = addr_err_q;

endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// Self-checking bench for pwm_cfg_arbiter: directed vector table, hand-written
// init_clr / rst sequences, and random traffic against a behavioural model.
module tb_pwm_cfg_arbiter;

  logic       clk;
  logic       rst, init_clr;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_addr, req1_addr;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       init_done, wr_strobe, wr_src, addr_err;
  logic [2:0] wr_addr;

  int checks = 0;
  int errors = 0;

  pwm_cfg_arbiter dut (
    .clk(clk), .rst(rst), .init_clr(init_clr),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .init_done(init_done), .wr_strobe(wr_strobe),
    .wr_src(wr_src), .wr_addr(wr_addr), .addr_err(addr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: register image, remaining default-load cycles, last winner.
  logic [7:0] m_regs [5];
  int         m_left;
  logic       m_last, m_done, m_strobe, m_src, m_aerr, m_known;
  logic [2:0] m_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic predict(output logic p0, output logic p1);
    p0 = 1'b0;
    p1 = 1'b0;
    if (m_left == 0 && !init_clr) begin
      if (req0_valid && req1_valid) begin
`ifdef PWM_CFG_ARB_FIXED_PRIO_EN
        p0 = 1'b1;
`else
        if (m_last == 1'b0) p1 = 1'b1; else p0 = 1'b1;
`endif
      end else begin
        p0 = req0_valid;
        p1 = req1_valid;
      end
    end
  endtask

  task automatic model_edge(input logic p0, input logic p1);
    logic [2:0] a;
    logic [7:0] d;
    if (rst) begin
      for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
      m_left = 5; m_last = 1'b1; m_done = 1'b0; m_strobe = 1'b0;
      m_src = 1'b0; m_addr = 3'd0; m_aerr = 1'b0; m_known = 1'b1;
    end else if (init_clr) begin
      m_left = 5; m_done = 1'b0; m_strobe = 1'b0; m_aerr = 1'b0;
    end else if (m_left > 0) begin
      m_regs[5 - m_left] = (m_left == 1) ? 8'h80 : 8'h00;
      m_left--;
      m_done = (m_left == 0);
      m_strobe = 1'b0; m_aerr = 1'b0;
    end else begin
      m_strobe = 1'b0; m_aerr = 1'b0;
      if (p0 || p1) begin
        a = p1 ? req1_addr : req0_addr;
        d = p1 ? req1_data : req0_data;
        m_last = p1;
        if (a < 3'd5) begin
          m_regs[a] = d; m_strobe = 1'b1; m_src = p1; m_addr = a;
        end else begin
          m_aerr = 1'b1;
        end
      end
    end
  endtask

  // One clock: check readies mid-cycle, advance model at the edge, check outputs after it.
  task automatic step(output logic r0, output logic r1);
    logic p0, p1;
    @(negedge clk);
    predict(p0, p1);
    r0 = req0_ready;
    r1 = req1_ready;
    if (m_known) begin
      chk("ready0", r0, p0);
      chk("ready1", r1, p1);
    end
    @(posedge clk);
    model_edge(p0, p1);
    #1;
    chk("reg0", en_reg_out_7_0, m_regs[0]);
    chk("reg1", en_reg_out_15_8, m_regs[1]);
    chk("reg2", en_reg_pwm_7_0, m_regs[2]);
    chk("reg3", en_reg_pwm_15_8, m_regs[3]);
    chk("duty", pwm_duty_cycle, m_regs[4]);
    chk("init_done", init_done, m_done);
    chk("wr_strobe", wr_strobe, m_strobe);
    chk("wr_src", wr_src, m_src);
    chk("wr_addr", wr_addr, m_addr);
    chk("addr_err", addr_err, m_aerr);
  endtask

  task automatic drive(input logic c, input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                       input logic v1, input logic [2:0] a1, input logic [7:0] d1);
    init_clr = c; req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  typedef struct {
    logic       clr, v0, v1;
    logic [2:0] a0, a1;
    logic [7:0] d0, d1;
    logic       e_r0, e_r1, e_strobe, e_src, e_aerr, e_done;
    logic [2:0] e_addr;
    logic [7:0] e_duty;
  } vec_t;

  vec_t vecs [9];
  logic r0, r1;

  initial begin
    m_known = 1'b0; m_left = 5; m_last = 1'b1;
    for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);

    // Tie-break expectations for the first four rows depend on the build.
    for (int i = 0; i < 4; i++) begin
      vecs[i] = '{clr:1'b0, v0:1'b1, a0:3'd0, d0:8'hAA, v1:1'b1, a1:3'd1, d1:8'h55,
                  e_r0:1'b1, e_r1:1'b0, e_strobe:1'b1, e_src:1'b0, e_aerr:1'b0,
                  e_done:1'b1, e_addr:3'd0, e_duty:8'h80};
`ifndef PWM_CFG_ARB_FIXED_PRIO_EN
      if (i % 2 == 1) begin
        vecs[i].e_r0 = 1'b0; vecs[i].e_r1 = 1'b1; vecs[i].e_src = 1'b1; vecs[i].e_addr = 3'd1;
      end
`endif
    end
    vecs[4] = '{clr:1'b0, v0:1'b1, a0:3'd4, d0:8'h3C, v1:1'b0, a1:3'd0, d1:8'h00,
                e_r0:1'b1, e_r1:1'b0, e_strobe:1'b1, e_src:1'b0, e_aerr:1'b0,
                e_done:1'b1, e_addr:3'd4, e_duty:8'h3C};
    vecs[5] = '{clr:1'b0, v0:1'b0, a0:3'd0, d0:8'h00, v1:1'b1, a1:3'd6, d1:8'hFF,
                e_r0:1'b0, e_r1:1'b1, e_strobe:1'b0, e_src:1'b0, e_aerr:1'b1,
                e_done:1'b1, e_addr:3'd4, e_duty:8'h3C};
    vecs[6] = '{clr:1'b0, v0:1'b0, a0:3'd0, d0:8'h00, v1:1'b0, a1:3'd0, d1:8'h00,
                e_r0:1'b0, e_r1:1'b0, e_strobe:1'b0, e_src:1'b0, e_aerr:1'b0,
                e_done:1'b1, e_addr:3'd4, e_duty:8'h3C};
    vecs[7] = '{clr:1'b0, v0:1'b1, a0:3'd4, d0:8'h10, v1:1'b0, a1:3'd0, d1:8'h00,
                e_r0:1'b1, e_r1:1'b0, e_strobe:1'b1, e_src:1'b0, e_aerr:1'b0,
                e_done:1'b1, e_addr:3'd4, e_duty:8'h10};
    vecs[8] = '{clr:1'b1, v0:1'b1, a0:3'd4, d0:8'h77, v1:1'b0, a1:3'd0, d1:8'h00,
                e_r0:1'b0, e_r1:1'b0, e_strobe:1'b0, e_src:1'b0, e_aerr:1'b0,
                e_done:1'b0, e_addr:3'd4, e_duty:8'h10};

    // Reset, then the five-cycle default load.
    step(r0, r1);
    step(r0, r1);
    chk("rst_duty", pwm_duty_cycle, 8'h00);
    chk("rst_done", init_done, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(r0, r1);
      chk("init_ready0", r0, 1'b0);
      chk("init_done_seq", init_done, (i == 4) ? 1'b1 : 1'b0);
    end
    chk("init_duty", pwm_duty_cycle, 8'h80);

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].clr, vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
      step(r0, r1);
      chk("vec_ready0", r0, vecs[i].e_r0);
      chk("vec_ready1", r1, vecs[i].e_r1);
      chk("vec_strobe", wr_strobe, vecs[i].e_strobe);
      chk("vec_src", wr_src, vecs[i].e_src);
      chk("vec_addr", wr_addr, vecs[i].e_addr);
      chk("vec_aerr", addr_err, vecs[i].e_aerr);
      chk("vec_done", init_done, vecs[i].e_done);
      chk("vec_duty", pwm_duty_cycle, vecs[i].e_duty);
    end

    // Default load after the soft clear restores duty.
    drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(r0, r1);
      chk("clr_done_seq", init_done, (i == 4) ? 1'b1 : 1'b0);
    end
    chk("clr_duty", pwm_duty_cycle, 8'h80);
    chk("clr_reg0", en_reg_out_7_0, 8'h00);

    // Soft clear, then another clear at INIT cycle 3 restarts the count.
    init_clr = 1'b1; step(r0, r1);
    init_clr = 1'b0; step(r0, r1); step(r0, r1);
    init_clr = 1'b1; step(r0, r1);
    init_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(r0, r1);
      chk("restart_done", init_done, 1'b0);
    end
    // Reset wins over a simultaneous soft clear.
    rst = 1'b1; init_clr = 1'b1; step(r0, r1);
    chk("rstclr_duty", pwm_duty_cycle, 8'h00);
    chk("rstclr_done", init_done, 1'b0);
    rst = 1'b0; init_clr = 1'b0;
    for (int i = 0; i < 5; i++) step(r0, r1);
    chk("rstclr_final_done", init_done, 1'b1);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 39) == 0,
            $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
            $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom));
      step(r0, r1);
      if (r0 && r1) begin
        checks++; errors++;
        $display("FAIL both_ready actual=1 required=0 at %0t", $time);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_cfg_arbiter.md
Name: pwm_cfg_arbiter

Overview:
Owns the PWM configuration register bank: en_reg_out[15:0], en_reg_pwm[15:0] and pwm_duty_cycle.
- Shares write access between two requesters:
  - port 0: decoded SPI writes
  - port 1: on-chip sequencer or test master
- After reset or a soft clear, runs a default-load sequence before granting either requester.
- Register outputs feed the PWM/output stage directly.

Parameters:
OUT_DEFAULT, 8'h00, value loaded into regs 0..3 during INIT
DUTY_DEFAULT, 8'h80, value loaded into reg 4 (duty) during INIT

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
init_clr  in  1  synchronous soft clear; restarts default-load sequence
req0_valid  in  1  requester 0 write request
req0_addr  in  3  requester 0 register address
req0_data  in  8  requester 0 write data
req0_ready  out  1  requester 0 accept (combinational)
req1_valid  in  1  requester 1 write request
req1_addr  in  3  requester 1 register address
req1_data  in  8  requester 1 write data
req1_ready  out  1  requester 1 accept (combinational)
en_reg_out_7_0  out  8  reg 0
en_reg_out_15_8  out  8  reg 1
en_reg_pwm_7_0  out  8  reg 2
en_reg_pwm_15_8  out  8  reg 3
pwm_duty_cycle  out  8  reg 4
init_done  out  1  high while in RUN
wr_strobe  out  1  one-cycle pulse: a register was written by a requester
wr_src  out  1  requester that caused the last wr_strobe
wr_addr  out  3  address of the last requester write
addr_err  out  1  one-cycle pulse: accepted request had address >4

Behaviour:
Reset (rst=1 at a clk edge):
- All five regs 0.
- init_done=0, wr_strobe=0, wr_src=0, wr_addr=0, addr_err=0.
- last_winner=1, state=INIT, cnt=0.

States: INIT, RUN.

INIT:
- Each cycle writes reg[cnt]: OUT_DEFAULT for cnt 0..3, DUTY_DEFAULT for cnt 4. Then cnt++.
- The write at cnt=4 moves the state to RUN.
- Duration is exactly 5 cycles. init_done rises in the first RUN cycle.
- Both readies are 0. INIT writes do not pulse wr_strobe.

RUN:
- Arbitration is combinational from valids:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester != last_winner (round-robin). First tie after reset goes to req0.
- reqN_ready = (state==RUN) & grant_N & !init_clr. Never both high.
- Handshake is valid & ready in the same cycle. last_winner updates to the accepted requester on the handshake edge.
- Valid address (0..4):
  - Register updates at the handshake edge and is visible the next cycle (latency 1).
  - wr_strobe=1 for that cycle, with wr_src/wr_addr set.
- Invalid address (5..7):
  - Request is still accepted (ready high) so the requester never stalls.
  - No register change, no wr_strobe. addr_err=1 the following cycle.
- Throughput is one write per cycle. A requester holding valid across consecutive ties alternates with the other requester.
- Requesters must hold addr/data stable while valid && !ready. The arbiter does not check this.

init_clr:
- Sampled synchronously in either state.
- Next state is INIT with cnt=0, init_done=0. The register contents are not zeroed first; the defaults overwrite them over 5 cycles.
- A request presented in the same cycle as init_clr is not accepted, because ready is gated.
- init_clr during INIT restarts the count at 0.

rst overrides init_clr.

Optional Feature:
PWM_CFG_ARB_FIXED_PRIO_EN:
- Defined: fixed priority, req0 always wins a tie. last_winner is unused and the req1 starvation risk is accepted by design.
- Undefined: round-robin as described above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then idle 5 cycles -> regs 0..3 = 8'h00, duty = 8'h80; init_done=0 through cycle 5, init_done=1 in cycle 6; readies 0 during INIT.
- RUN, req0 addr=4 data=8'h3C alone -> req0_ready=1 same cycle; next cycle pwm_duty_cycle=8'h3C, wr_strobe=1, wr_src=0, wr_addr=4.
- Both valid for 4 cycles (req0 addr0 8'hAA, req1 addr1 8'h55), held -> grants 0,1,0,1. Under PWM_CFG_ARB_FIXED_PRIO_EN, grants are 0,0,0,0 and req1 never ready.
- req1 addr=6 data=8'hFF -> req1_ready=1; next cycle addr_err=1, wr_strobe=0, all regs unchanged.
- RUN with duty=8'h10, then init_clr plus req0 valid same cycle -> req0_ready=0, no write; 5 INIT cycles; duty returns to 8'h80; init_done=1 afterwards.
- init_clr asserted at INIT cycle 3, then rst asserted together with init_clr -> INIT restarts at cnt=0 and lasts 5 more cycles; rst wins, all regs 0.
